// File: rtl/crc16_rx_checker.sv
// Serial CRC-16 receive checker: divides a framed MSB-first bitstream by POLY,
// recovers the message bits and reports the syndrome with a one-cycle Done pulse.
module crc16_rx_checker #(
  parameter int unsigned      DATA_W = 4,
  parameter int unsigned      CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = 16'h8005
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Sin,
  input  logic              Sin_valid,
  output logic              Busy,
  output logic              Done,
  output logic              Crc_ok,
  output logic [DATA_W-1:0] Dout,
  output logic [CRC_W-1:0]  Crc_rem,
  output logic              Abort
);

  localparam int unsigned N     = DATA_W + CRC_W;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    REPORT
  } state_t;

  state_t             state;
  logic [CRC_W-1:0]   rem;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  data;

  // Receiver FSM with GF(2) remainder LFSR and payload shifter
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Crc_ok  <= 1'b0;
      Abort   <= 1'b0;
      Dout    <= '0;
      Crc_rem <= '0;
      rem     <= '0;
      cnt     <= '0;
      data    <= '0;
    end else begin
      Done  <= 1'b0;
      Abort <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state  <= RECV;
            Busy   <= 1'b1;
            rem    <= '0;
            cnt    <= '0;
            data   <= '0;
            Crc_ok <= 1'b0;
          end
        end
        RECV: begin
          // Start wins over a valid bit; that bit is dropped with the frame
          if (Start) begin
            Abort <= 1'b1;
            rem   <= '0;
            cnt   <= '0;
            data  <= '0;
          end else if (Sin_valid) begin
            rem <= {rem[CRC_W-2:0], Sin} ^ ({CRC_W{rem[CRC_W-1]}} & POLY);
            cnt <= cnt + CNT_W'(1);
            if (cnt < CNT_W'(DATA_W)) begin
              data <= {data[DATA_W-2:0], Sin};
            end
            if (cnt == CNT_W'(N - 1)) begin
              state <= REPORT;
              Busy  <= 1'b0;
            end
          end
        end
        REPORT: begin
          Done    <= 1'b1;
          Crc_ok  <= (rem == '0);
          Crc_rem <= rem;
          Dout    <= data;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_rx_checker.sv
// Directed self-checking bench for crc16_rx_checker using hand-computed CRC-16/0x8005 frames.
module tb_crc16_rx_checker;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Sin;
  logic        Sin_valid;
  logic        Busy;
  logic        Done;
  logic        Crc_ok;
  logic [3:0]  Dout;
  logic [15:0] Crc_rem;
  logic        Abort;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  localparam logic [19:0] FRAME_GOOD  = 20'b1011_1000000000111001;
  localparam logic [19:0] FRAME_LAST  = 20'b1011_1000000000111000;
  localparam logic [19:0] FRAME_FIRST = 20'b0011_1000000000111001;
  localparam logic [19:0] FRAME_ZERO  = 20'b0;

  crc16_rx_checker dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Sin       (Sin),
    .Sin_valid (Sin_valid),
    .Busy      (Busy),
    .Done      (Done),
    .Crc_ok    (Crc_ok),
    .Dout      (Dout),
    .Crc_rem   (Crc_rem),
    .Abort     (Abort)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Count Done pulses and keep Done/Abort exclusive
  always @(negedge Clk) begin
    if (Reset) begin
      if (Done) done_cnt++;
      check("done_abort_excl", 32'(Done & Abort), 32'd0);
    end
  end

  task automatic start_frame();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
  endtask

  // Send the first n bits of f MSB first, with gap idle cycles after each non-final bit
  task automatic send_bits(input logic [19:0] f, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Sin       = f[19-i];
      Sin_valid = 1'b1;
      if (gap > 0 && i != 19) begin
        @(negedge Clk);
        Sin_valid = 1'b0;
        check("busy_gap", 32'(Busy), 32'd1);
        repeat (gap - 1) @(negedge Clk);
      end
    end
    @(negedge Clk);
    Sin_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (Done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [19:0] f, input int gap,
                           input logic exp_ok, input logic [3:0] exp_dout,
                           input logic [15:0] exp_rem);
    int lat;
    send_bits(f, 20, gap);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd1);
    check({tag, "_crc_ok"},  32'(Crc_ok), 32'(exp_ok));
    check({tag, "_dout"},    32'(Dout), 32'(exp_dout));
    check({tag, "_crc_rem"}, 32'(Crc_rem), 32'(exp_rem));
    @(negedge Clk);
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
    check({tag, "_hold_rem"},   32'(Crc_rem), 32'(exp_rem));
  endtask

  initial begin
    int d0;
    Reset = 1'b0; Start = 1'b0; Sin = 1'b0; Sin_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_busy",    32'(Busy), 32'd0);
    check("rst_done",    32'(Done), 32'd0);
    check("rst_crc_ok",  32'(Crc_ok), 32'd0);
    check("rst_dout",    32'(Dout), 32'd0);
    check("rst_crc_rem", 32'(Crc_rem), 32'd0);
    check("rst_abort",   32'(Abort), 32'd0);
    Reset = 1'b1;

    // T1 good frame
    start_frame();
    check("t1_busy", 32'(Busy), 32'd1);
    run_frame("t1", FRAME_GOOD, 0, 1'b1, 4'hB, 16'h0000);
    check("t1_busy_after", 32'(Busy), 32'd0);

    // T2 last-bit flip
    start_frame();
    run_frame("t2", FRAME_LAST, 0, 1'b0, 4'hB, 16'h0001);

    // T3 first-bit flip
    start_frame();
    run_frame("t3", FRAME_FIRST, 0, 1'b0, 4'h3, 16'h8033);

    // T4 gapped input
    d0 = done_cnt;
    start_frame();
    run_frame("t4", FRAME_GOOD, 3, 1'b1, 4'hB, 16'h0000);
    repeat (3) @(negedge Clk);
    check("t4_done_once", 32'(done_cnt - d0), 32'd1);

    // T5 mid-frame restart; the bit on the Start edge is discarded
    start_frame();
    send_bits(FRAME_FIRST, 7, 0);
    @(negedge Clk);
    Start = 1'b1; Sin = 1'b1; Sin_valid = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Sin_valid = 1'b0;
    check("t5_abort", 32'(Abort), 32'd1);
    check("t5_busy",  32'(Busy), 32'd1);
    @(negedge Clk);
    check("t5_abort_pulse", 32'(Abort), 32'd0);
    run_frame("t5", FRAME_GOOD, 0, 1'b1, 4'hB, 16'h0000);

    // T6 reset mid-frame
    start_frame();
    send_bits(FRAME_GOOD, 10, 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("t6_busy",    32'(Busy), 32'd0);
    check("t6_done",    32'(Done), 32'd0);
    check("t6_crc_ok",  32'(Crc_ok), 32'd0);
    check("t6_dout",    32'(Dout), 32'd0);
    check("t6_crc_rem", 32'(Crc_rem), 32'd0);
    check("t6_abort",   32'(Abort), 32'd0);
    Reset = 1'b1;
    d0 = done_cnt;
    Sin = 1'b1; Sin_valid = 1'b1;
    repeat (25) @(negedge Clk);
    Sin_valid = 1'b0;
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_idle_busy", 32'(Busy), 32'd0);
    start_frame();
    run_frame("t6", FRAME_ZERO, 0, 1'b1, 4'h0, 16'h0000);

    repeat (2) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
